// File: rtl/life_sequencer.sv
// life_sequencer
//
// Top-level sequencer for the cellular-automaton grid datapath. It holds the
// grid in reset until a start press, then runs the LFSR for a fixed seeding
// window and loads the random pattern into the grid. After that it advances
// generations at a programmable rate. Pause, single-step and reseed come from
// debounced buttons.
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset      synchronous, active-high reset
//   i_start      start button level (rising edge used)
//   i_pause      pause button level (rising edge toggles run/pause)
//   i_step       step button level (rising edge = one generation while paused)
//   i_reseed     reseed button level (rising edge restarts seeding)
//   i_period     clock cycles per generation in RUN; 0 behaves as 1
//   o_lfsr_en    LFSR advance enable
//   o_grid_load  one-cycle pulse, grid captures the LFSR pattern
//   o_grid_rst   grid clear
//   o_grid_en    one-cycle pulse, grid computes the next generation
//   o_running    high while free-running
//   o_gen_count  generations since the last seed, wraps silently
//
// All outputs are registered. The output comb process works out each output's
// value for the coming cycle from the next state, and the register process
// captures it.

module life_sequencer #(
   parameter int unsigned SEED_CYCLES = 64,
   parameter int unsigned DIV_W       = 24,
   parameter int unsigned GEN_W       = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_pause,
   input  logic             i_step,
   input  logic             i_reseed,
   input  logic [DIV_W-1:0] i_period,
   output logic             o_lfsr_en,
   output logic             o_grid_load,
   output logic             o_grid_rst,
   output logic             o_grid_en,
   output logic             o_running,
   output logic [GEN_W-1:0] o_gen_count
);

   localparam int unsigned      SeedW    = (SEED_CYCLES > 1) ? $clog2(SEED_CYCLES) : 1;
   localparam logic [SeedW-1:0] SeedLast = SeedW'(SEED_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StSeed  = 2'd1,
      StRun   = 2'd2,
      StPause = 2'd3
   } state_e;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_e             r_state;
   logic               r_start_prev;
   logic               r_pause_prev;
   logic               r_step_prev;
   logic               r_reseed_prev;
   logic [SeedW-1:0]   r_seed_cnt;
   logic [DIV_W-1:0]   r_cnt;
   logic [GEN_W-1:0]   r_gen_count;
   logic               r_lfsr_en;
   logic               r_grid_load;
   logic               r_grid_rst;
   logic               r_grid_en;
   logic               r_running;

   // ------------------------------------------------------------------
   // Wires
   // ------------------------------------------------------------------
   logic               w_start_edge;
   logic               w_pause_edge;
   logic               w_step_edge;
   logic               w_reseed_edge;
   state_e             w_state_next;
   logic               w_seed_restart;
   logic [SeedW-1:0]   w_seed_cnt_next;
   logic [DIV_W-1:0]   w_period_m1;
   logic [DIV_W-1:0]   w_cnt_next;
   logic               w_run_tick;
   logic               w_step_tick;
   logic               w_grid_en_next;
   logic [GEN_W-1:0]   w_gen_count_next;
   logic               w_lfsr_en_next;
   logic               w_grid_load_next;
   logic               w_grid_rst_next;
   logic               w_running_next;

   // Rising-edge detection. The previous-value registers reset high, so a
   // button held through reset must be released and pressed again to count.
   assign w_start_edge  = i_start  & ~r_start_prev;
   assign w_pause_edge  = i_pause  & ~r_pause_prev;
   assign w_step_edge   = i_step   & ~r_step_prev;
   assign w_reseed_edge = i_reseed & ~r_reseed_prev;

   // period of 0 behaves as 1, so the terminal count never underflows
   assign w_period_m1 = (i_period == '0) ? '0 : (i_period - DIV_W'(1));

   // ------------------------------------------------------------------
   // Process 1: state and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= StIdle;
         r_start_prev  <= 1'b1;
         r_pause_prev  <= 1'b1;
         r_step_prev   <= 1'b1;
         r_reseed_prev <= 1'b1;
         r_seed_cnt    <= '0;
         r_cnt         <= '0;
         r_gen_count   <= '0;
         r_lfsr_en     <= 1'b0;
         r_grid_load   <= 1'b0;
         r_grid_rst    <= 1'b1;
         r_grid_en     <= 1'b0;
         r_running     <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_start_prev  <= i_start;
         r_pause_prev  <= i_pause;
         r_step_prev   <= i_step;
         r_reseed_prev <= i_reseed;
         r_seed_cnt    <= w_seed_cnt_next;
         r_cnt         <= w_cnt_next;
         r_gen_count   <= w_gen_count_next;
         r_lfsr_en     <= w_lfsr_en_next;
         r_grid_load   <= w_grid_load_next;
         r_grid_rst    <= w_grid_rst_next;
         r_grid_en     <= w_grid_en_next;
         r_running     <= w_running_next;
      end
   end

   // ------------------------------------------------------------------
   // Process 2: next-state logic
   // Priority: reseed > pause > step/divider tick.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            // reseed is ignored here; only start leaves IDLE
            if (w_start_edge) begin
               w_state_next = StSeed;
            end
         end
         StSeed: begin
            if (w_reseed_edge) begin
               w_state_next = StSeed;
            end else if (r_seed_cnt == SeedLast) begin
               w_state_next = StRun;
            end
         end
         StRun: begin
            if (w_reseed_edge) begin
               w_state_next = StSeed;
            end else if (w_pause_edge) begin
               w_state_next = StPause;
            end
         end
         StPause: begin
            if (w_reseed_edge) begin
               w_state_next = StSeed;
            end else if (w_pause_edge || w_start_edge) begin
               w_state_next = StRun;
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Process 3: output and counter next values
   // ------------------------------------------------------------------
   always_comb begin
      w_seed_restart   = 1'b0;
      w_seed_cnt_next  = '0;
      w_cnt_next       = '0;
      w_run_tick       = 1'b0;
      w_step_tick      = 1'b0;
      w_grid_en_next   = 1'b0;
      w_gen_count_next = r_gen_count;
      w_lfsr_en_next   = 1'b0;
      w_grid_load_next = 1'b0;
      w_grid_rst_next  = 1'b0;
      w_running_next   = 1'b0;

      // Seeding starts over on entry from any other state and on a reseed
      // edge while already seeding.
      if (w_state_next == StSeed) begin
         w_seed_restart = (r_state != StSeed) || w_reseed_edge;
         if (w_seed_restart) begin
            w_seed_cnt_next = '0;
         end else begin
            w_seed_cnt_next = r_seed_cnt + SeedW'(1);
         end
      end

      // r_cnt is the position of the current RUN cycle within the period.
      // It restarts at 0 on entry to RUN and after every tick. The >= test
      // makes a lowered period tick on the very next cycle.
      if (w_state_next == StRun) begin
         if ((r_state != StRun) || r_grid_en) begin
            w_cnt_next = '0;
         end else begin
            w_cnt_next = r_cnt + DIV_W'(1);
         end
         w_run_tick = (w_cnt_next >= w_period_m1);
      end

      // A step counts only when PAUSE is kept. A reseed in the same cycle
      // leaves PAUSE and so swallows the step.
      w_step_tick = (r_state == StPause) && (w_state_next == StPause) && w_step_edge;

      w_grid_en_next = w_run_tick | w_step_tick;

      if (w_seed_restart) begin
         w_gen_count_next = '0;
      end else if (w_grid_en_next) begin
         w_gen_count_next = r_gen_count + GEN_W'(1);
      end

      w_lfsr_en_next   = (w_state_next == StSeed);
      w_grid_load_next = (w_state_next == StSeed) && (w_seed_cnt_next == SeedLast);
      w_grid_rst_next  = (w_state_next == StIdle);
      w_running_next   = (w_state_next == StRun);
   end

   assign o_lfsr_en   = r_lfsr_en;
   assign o_grid_load = r_grid_load;
   assign o_grid_rst  = r_grid_rst;
   assign o_grid_en   = r_grid_en;
   assign o_running   = r_running;
   assign o_gen_count = r_gen_count;

endmodule

// File: tb/tb_life_sequencer.sv
// tb_life_sequencer
//
// Scoreboard bench for life_sequencer (SEED_CYCLES=4, DIV_W=8, GEN_W=4).
// The stimulus thread pushes each expected grid_load/grid_en pulse (cycle
// number and gen_count) into a queue. The monitor thread pops one entry for
// every pulse the DUT shows. Level checks (running, grid_rst, ...) are made
// directly at chosen cycles.

module tb_life_sequencer;

   localparam int unsigned SeedCycles = 4;
   localparam int unsigned DivW       = 8;
   localparam int unsigned GenW       = 4;

   localparam logic [3:0] BStart  = 4'b0001;
   localparam logic [3:0] BPause  = 4'b0010;
   localparam logic [3:0] BStep   = 4'b0100;
   localparam logic [3:0] BReseed = 4'b1000;

   typedef struct {
      bit ld;
      int cyc;
      int gen;
   } exp_t;

   logic            clk;
   logic            reset;
   logic            start;
   logic            pause;
   logic            step;
   logic            reseed;
   logic [DivW-1:0] period;
   logic            lfsr_en;
   logic            grid_load;
   logic            grid_rst;
   logic            grid_en;
   logic            running;
   logic [GenW-1:0] gen_count;

   int   cyc;
   int   checks;
   int   failures;
   int   lfsr_cnt;
   bit   done;
   exp_t exp_q[$];

   life_sequencer #(
      .SEED_CYCLES(SeedCycles),
      .DIV_W      (DivW),
      .GEN_W      (GenW)
   ) u_dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_start    (start),
      .i_pause    (pause),
      .i_step     (step),
      .i_reseed   (reseed),
      .i_period   (period),
      .o_lfsr_en  (lfsr_en),
      .o_grid_load(grid_load),
      .o_grid_rst (grid_rst),
      .o_grid_en  (grid_en),
      .o_running  (running),
      .o_gen_count(gen_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) next_cyc();
   endtask

   task automatic at_neg(input int c);
      @(negedge clk);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic push(input bit ld, input int c, input int g);
      exp_t e;
      e.ld  = ld;
      e.cyc = c;
      e.gen = g;
      exp_q.push_back(e);
   endtask

   // Drive a one-cycle press; n is the cycle whose outputs show its effect.
   task automatic pulse(input logic [3:0] m, output int n);
      start  = m[0];
      pause  = m[1];
      step   = m[2];
      reseed = m[3];
      n = cyc + 1;
      next_cyc();
      start  = 1'b0;
      pause  = 1'b0;
      step   = 1'b0;
      reseed = 1'b0;
      next_cyc();
   endtask

   task automatic monitor();
      exp_t e;
      while (!done) begin
         @(negedge clk);
         if (lfsr_en) lfsr_cnt++;
         if (grid_en || grid_load) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse_cycle", cyc, -1);
            end else begin
               e = exp_q.pop_front();
               check("pulse_cycle", cyc, e.cyc);
               check("pulse_is_load", int'(grid_load), int'(e.ld));
               check("pulse_gen_count", int'(gen_count), e.gen);
               check("en_load_exclusive", int'(grid_en & grid_load), 0);
            end
         end
      end
   endtask

   task automatic stimulus();
      int n, p, r, s, k, n2, n3, n4;

      // reset state
      repeat (2) next_cyc();
      at_neg(cyc);
      check("rst_grid_rst", int'(grid_rst), 1);
      check("rst_lfsr_en", int'(lfsr_en), 0);
      check("rst_grid_load", int'(grid_load), 0);
      check("rst_grid_en", int'(grid_en), 0);
      check("rst_running", int'(running), 0);
      check("rst_gen_count", int'(gen_count), 0);
      next_cyc();
      reset = 1'b0;
      repeat (2) next_cyc();

      // start -> seed 4 cycles -> run with period 3
      lfsr_cnt = 0;
      pulse(BStart, n);
      push(1'b1, n + 3, 0);
      push(1'b0, n + 6, 1);
      push(1'b0, n + 9, 2);
      push(1'b0, n + 12, 3);
      at_neg(n + 1);
      check("seed_grid_rst", int'(grid_rst), 0);
      check("seed_lfsr_en", int'(lfsr_en), 1);
      at_neg(n + 3);
      check("seed_last_running", int'(running), 0);
      at_neg(n + 4);
      check("run_entry_running", int'(running), 1);
      at_neg(n + 5);
      check("seed_lfsr_cycles", lfsr_cnt, 4);
      check("run_lfsr_en", int'(lfsr_en), 0);

      // period 5, pause edge on the tick cycle, 3 steps, resume
      wait_cyc(n + 12);
      period = 8'd5;
      push(1'b0, n + 17, 4);
      wait_cyc(n + 21);
      pulse(BPause, p);
      at_neg(p + 1);
      check("pause_running", int'(running), 0);
      check("pause_gen_count", int'(gen_count), 4);
      for (int i = 0; i < 3; i++) begin
         push(1'b0, cyc + 1, 5 + i);
         pulse(BStep, k);
      end
      pulse(BPause, r);
      push(1'b0, r + 4, 8);
      at_neg(r + 1);
      check("resume_running", int'(running), 1);

      // period 0 and 1: tick every cycle; then 100 -> 2 with cnt at 50
      wait_cyc(r + 4);
      period = 8'd0;
      push(1'b0, r + 5, 9);
      push(1'b0, r + 6, 10);
      push(1'b0, r + 7, 11);
      wait_cyc(r + 7);
      period = 8'd1;
      push(1'b0, r + 8, 12);
      push(1'b0, r + 9, 13);
      wait_cyc(r + 9);
      period = 8'd100;
      wait_cyc(r + 60);
      period = 8'd2;
      push(1'b0, r + 61, 14);
      push(1'b0, r + 63, 15);
      push(1'b0, r + 65, 0);
      push(1'b0, r + 67, 1);
      at_neg(r + 65);
      check("wrap_running", int'(running), 1);

      // reseed edge on a would-be tick, then reset mid-seed
      wait_cyc(r + 67);
      period = 8'd3;
      wait_cyc(r + 69);
      pulse(BReseed, s);
      at_neg(s + 1);
      check("reseed_gen_count", int'(gen_count), 0);
      check("reseed_running", int'(running), 0);
      check("reseed_lfsr_en", int'(lfsr_en), 1);
      reset = 1'b1;
      at_neg(s + 2);
      check("abort_grid_rst", int'(grid_rst), 1);
      check("abort_lfsr_en", int'(lfsr_en), 0);

      // start held through reset fires nothing; reseed ignored in IDLE
      start = 1'b1;
      repeat (2) next_cyc();
      reset = 1'b0;
      repeat (4) next_cyc();
      at_neg(cyc);
      check("held_start_grid_rst", int'(grid_rst), 1);
      check("held_start_lfsr_en", int'(lfsr_en), 0);
      start = 1'b0;
      next_cyc();
      pulse(BReseed, k);
      at_neg(cyc);
      check("idle_reseed_grid_rst", int'(grid_rst), 1);

      // reseed in SEED restarts the seed window
      lfsr_cnt = 0;
      pulse(BStart, n2);
      pulse(BReseed, n3);
      push(1'b1, n3 + 3, 0);
      at_neg(n3 + 5);
      check("reseed_seed_lfsr_cycles", lfsr_cnt, 6);
      check("reseed_seed_running", int'(running), 1);
      push(1'b0, n3 + 6, 1);

      // pause, then reseed together with step: SEED, no grid_en
      wait_cyc(n3 + 7);
      pulse(BPause, k);
      pulse(BReseed | BStep, n4);
      push(1'b1, n4 + 3, 0);
      push(1'b0, n4 + 6, 1);
      push(1'b0, n4 + 9, 2);
      at_neg(n4 + 1);
      check("reseed_step_gen_count", int'(gen_count), 0);
      check("reseed_step_lfsr_en", int'(lfsr_en), 1);
      wait_cyc(n4 + 10);
      done = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      lfsr_cnt = 0;
      done     = 1'b0;
      reset    = 1'b1;
      start    = 1'b0;
      pause    = 1'b0;
      step     = 1'b0;
      reseed   = 1'b0;
      period   = 8'd3;
      fork
         monitor();
         stimulus();
      join
      check("pulses_left_unseen", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/life_sequencer.md
# life_sequencer

Top-level sequencer for the cellular-automaton grid datapath. It holds the grid in reset until `start`, runs the LFSR for a fixed seeding window, and loads the random pattern into the grid. It then advances generations at a programmable rate, with pause, single-step and reseed controls from debounced board buttons. It replaces ad-hoc enable wiring between the LFSR, the grid and the display tick.

## Interface
Parameters:
- `SEED_CYCLES`, 64: cycles `lfsr_en` is held during seeding; must be ≥ 1.
- `DIV_W`, 24: width of the generation-period divider.
- `GEN_W`, 16: width of the generation counter.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level from debouncer; rising edge used.
- `pause`  in  1  level; rising edge toggles run/pause.
- `step`  in  1  level; rising edge advances one generation while paused.
- `reseed`  in  1  level; rising edge restarts seeding.
- `period`  in  DIV_W  clock cycles per generation in RUN; 0 treated as 1.
- `lfsr_en`  out  1  LFSR advance enable.
- `grid_load`  out  1  one-cycle pulse: grid captures the LFSR pattern.
- `grid_rst`  out  1  grid clear.
- `grid_en`  out  1  one-cycle pulse: grid computes the next generation.
- `running`  out  1  high in RUN.
- `gen_count`  out  GEN_W  generations since last seed; wraps modulo 2^GEN_W.

## Operation
- States: IDLE, SEED, RUN, PAUSE. Encoding is free; unused encodings return to IDLE.
- Edge detect: one previous-value register per button input.
  - Edge = input high now AND previous low.
  - Previous registers reset to 1, so a button held through reset fires nothing until it is released and pressed again.
- IDLE: `grid_rst`=1. A start edge moves to SEED.
- SEED:
  - `lfsr_en`=1 for exactly SEED_CYCLES cycles.
  - `grid_load`=1 on the last of those cycles only.
  - Then moves to RUN.
  - `gen_count` clears to 0 on entry.
  - pause, step and start edges are ignored.
  - A reseed edge restarts the seed counter.
- RUN:
  - Divider `cnt` counts up from 0.
  - When `cnt` ≥ P−1, where P = max(`period`,1), assert `grid_en` for that cycle, set `cnt` to 0 and increment `gen_count`.
  - The ≥ comparison means lowering `period` mid-run ticks on the next cycle and never misses a tick.
- PAUSE:
  - Each step edge gives one `grid_en` pulse and a `gen_count`+1.
  - A pause or start edge moves to RUN with `cnt`=0.
- Event priority when several apply in the same cycle: reset > reseed > pause > step/divider tick.
  - In RUN, a pause edge coinciding with a tick moves to PAUSE and suppresses that `grid_en`.
  - In PAUSE, a reseed edge together with a step edge moves to SEED with no `grid_en`.
- Reseed edge in RUN or PAUSE moves to SEED. In IDLE it is ignored; only start leaves IDLE.
- All outputs are registered. No combinational path from any input to any output.

## Timing
- Reset, effective at the next rising edge:
  - State = IDLE.
  - `grid_rst`=1.
  - `lfsr_en`=`grid_load`=`grid_en`=`running`=0.
  - `gen_count`=0, `cnt`=0, seed counter=0.
  - Reset mid-SEED or mid-RUN aborts immediately. No trailing `grid_load` or `grid_en`.
- Event latency: an edge sampled at clock edge N has its outputs visible in the cycle after edge N.
- start edge at N:
  - `grid_rst` drops and `lfsr_en` rises after N.
  - `lfsr_en` stays high through the cycle after N+SEED_CYCLES−1.
  - `grid_load` is high in that same final cycle.
  - `running`=1 after edge N+SEED_CYCLES.
- RUN: the first `grid_en` is in the P-th RUN cycle, and every P cycles after that. With P=1, `grid_en` is high every cycle.
- `gen_count` updates in the same cycle `grid_en` is high.
- `grid_en` and `grid_load` are never high in the same cycle. `grid_en` is never high in IDLE or SEED.
- `gen_count` wraps from 2^GEN_W−1 to 0 with no flag.

## Test plan
- Reset, then a start pulse with SEED_CYCLES=4, period=3 → `lfsr_en` high for exactly 4 cycles, `grid_load` only on the 4th, `running` rises next. `grid_en` pulses on RUN cycles 3, 6, 9, with `gen_count` = 1, 2, 3.
- Hold `start` high through reset → no SEED entry until `start` drops and rises again.
- In RUN with period=5, assert a pause edge exactly on the tick cycle → no `grid_en`, state PAUSE, `gen_count` unchanged. Then 3 step edges → 3 single-cycle `grid_en` pulses and `gen_count`+3. A pause edge resumes, with the first tick 5 cycles later.
- period=0 and period=1 → `grid_en` high every RUN cycle. Change period from 100 to 2 while `cnt`=50 → tick on the next cycle, then every 2 cycles.
- Reseed edge in RUN after 7 generations → SEED, `gen_count`=0, `grid_en` silent. Assert reset during SEED → IDLE next cycle, `grid_rst`=1, no `grid_load` pulse.
- GEN_W=4: run 17 ticks → `gen_count` goes 15 → 0 → 1, with `running` still 1.
